// File: rtl/acc_drain_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the conv3
// accumulator sequencer/drain block and its requantisation lanes.
package acc_drain_ctrl_pkg;

  // Datapath widths
  localparam int ADDER_BW     = 29;  // signed accumulator lane
  localparam int BW_PER_ACT   = 12;  // signed output activation
  localparam int BW_PER_PARAM = 8;   // signed bias
  localparam int CH_NUM       = 8;   // output channels per bank
  localparam int ACT_PER_ADDR = 4;   // pixels per channel word
  localparam int CNT_W        = 7;   // accumulator step counter
  localparam int SHIFT_W      = 5;   // requantisation shift amount
  localparam int CH_W         = 3;   // output channel index

  // Derived sizes
  localparam int LANES  = CH_NUM * ACT_PER_ADDR;
  localparam int WORD_W = ACT_PER_ADDR * BW_PER_ACT;

  // Saturation bounds of a BW_PER_ACT-bit signed activation
  localparam int ACT_MAX = 2047;
  localparam int ACT_MIN = -2048;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    CAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // True when the given channel index is the final word of the bank.
  function automatic logic is_last_ch(input logic [CH_W-1:0] ch);
    return ch == CH_W'(CH_NUM - 1);
  endfunction

endpackage

// File: rtl/acc_drain_ctrl_requant_lane.sv
// One requantisation lane: bias add, optional ReLU, round-half-up
// arithmetic right shift and saturation to activation width. Purely
// combinational; the caller registers the result.
module requant_lane
  import acc_drain_ctrl_pkg::*;
(
  input  logic [ADDER_BW-1:0]     acc,
  input  logic [BW_PER_PARAM-1:0] bias,
  input  logic                    relu_en,
  input  logic [SHIFT_W-1:0]      shift,
  output logic [BW_PER_ACT-1:0]   act
);

  // Wide enough that bias add and the largest rounding constant
  // (2^30 for shift=31) can never wrap.
  localparam int VW = ADDER_BW + 3;

  localparam logic signed [VW-1:0] ONE   = VW'(1);
  localparam logic signed [VW-1:0] MAX_V = VW'(ACT_MAX);
  localparam logic signed [VW-1:0] MIN_V = VW'(ACT_MIN);

  logic signed [VW-1:0] sum;
  logic signed [VW-1:0] rect;
  logic signed [VW-1:0] half;
  logic signed [VW-1:0] rounded;
  logic signed [VW-1:0] shifted;

  // Full-precision bias/ReLU/round/shift/saturate chain.
  always_comb begin
    sum  = {{(VW-ADDER_BW){acc[ADDER_BW-1]}}, acc}
         + {{(VW-BW_PER_PARAM){bias[BW_PER_PARAM-1]}}, bias};
    rect = (relu_en && sum[VW-1]) ? '0 : sum;
    half = (shift == '0) ? '0 : (ONE << (shift - SHIFT_W'(1)));
    rounded = rect + half;
    shifted = rounded >>> shift;
    if (shifted > MAX_V) begin
      act = MAX_V[BW_PER_ACT-1:0];
    end else if (shifted < MIN_V) begin
      act = MIN_V[BW_PER_ACT-1:0];
    end else begin
      act = shifted[BW_PER_ACT-1:0];
    end
  end

endmodule

// File: rtl/acc_drain_ctrl.sv
// Sequencer and consumer for the 8-channel, 4-pixel conv3 partial-sum
// accumulator: steps the accumulator counter, captures the final sums
// one cycle after the last step, requantises all 32 lanes, then drains
// one channel word per valid/ready handshake.
module acc_drain_ctrl
  import acc_drain_ctrl_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   srst_n,
  input  logic                                   start,
  input  logic [CNT_W-1:0]                       num_steps_m1,
  input  logic [SHIFT_W-1:0]                     shift,
  input  logic                                   relu_en,
  input  logic [CH_NUM*BW_PER_PARAM-1:0]         bias_vec,
  input  logic [CH_NUM*ACT_PER_ADDR*ADDER_BW-1:0] add_flat,
  output logic [CNT_W-1:0]                       counter,
  output logic                                   busy,
  output logic                                   wr_valid,
  input  logic                                   wr_ready,
  output logic [CH_W-1:0]                        wr_ch,
  output logic [WORD_W-1:0]                      wr_data,
  output logic                                   done
);

  // FSM and sequencing state
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] step_reg, step_next;
  logic [CH_W-1:0]  ch_reg, ch_next;
  // Set after the last word is accepted: the one DRAIN cycle that
  // carries the done pulse before returning to IDLE.
  logic             fin_reg, fin_next;
  logic             load_cfg;
  logic             capture;

  // Tile configuration, frozen at start
  logic [CNT_W-1:0]              steps_m1_reg;
  logic [SHIFT_W-1:0]            shift_reg;
  logic                          relu_reg;
  logic [CH_NUM*BW_PER_PARAM-1:0] bias_reg;

  // Requantised lanes and their per-channel capture registers
  logic [LANES*BW_PER_ACT-1:0] lane_act;
  logic [WORD_W-1:0]           res_reg [CH_NUM];

  // State register plus step/channel/finish bookkeeping.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      ch_reg    <= '0;
      fin_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      ch_reg    <= ch_next;
      fin_reg   <= fin_next;
    end
  end

  // Next-state logic and all FSM-driven outputs.
  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    ch_next    = ch_reg;
    fin_next   = fin_reg;
    load_cfg   = 1'b0;
    capture    = 1'b0;
    counter    = '0;
    busy       = 1'b1;
    wr_valid   = 1'b0;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        busy      = 1'b0;
        step_next = '0;
        ch_next   = '0;
        fin_next  = 1'b0;
        if (start) begin
          load_cfg   = 1'b1;
          state_next = ACC;
        end
      end

      ACC: begin
        counter = step_reg;
        // Stop at the programmed last step so the counter never wraps.
        if (step_reg == steps_m1_reg) begin
          step_next  = '0;
          state_next = CAP;
        end else begin
          step_next = step_reg + CNT_W'(1);
        end
      end

      CAP: begin
        // The accumulator's output register now holds the final sums.
        capture    = 1'b1;
        ch_next    = '0;
        fin_next   = 1'b0;
        state_next = DRAIN;
      end

      DRAIN: begin
        if (fin_reg) begin
          done       = 1'b1;
          fin_next   = 1'b0;
          state_next = IDLE;
        end else begin
          wr_valid = 1'b1;
          if (wr_ready) begin
            if (is_last_ch(ch_reg)) begin
              ch_next  = '0;
              fin_next = 1'b1;
            end else begin
              ch_next = ch_reg + CH_W'(1);
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the tile configuration on an accepted start.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      steps_m1_reg <= '0;
      shift_reg    <= '0;
      relu_reg     <= 1'b0;
      bias_reg     <= '0;
    end else if (load_cfg) begin
      steps_m1_reg <= num_steps_m1;
      shift_reg    <= shift;
      relu_reg     <= relu_en;
      bias_reg     <= bias_vec;
    end
  end

  // 32 requantisation lanes; lane index = ch*ACT_PER_ADDR + pixel.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      requant_lane u_lane (
        .acc     (add_flat[gi*ADDER_BW +: ADDER_BW]),
        .bias    (bias_reg[(gi/ACT_PER_ADDR)*BW_PER_PARAM +: BW_PER_PARAM]),
        .relu_en (relu_reg),
        .shift   (shift_reg),
        .act     (lane_act[gi*BW_PER_ACT +: BW_PER_ACT])
      );
    end
  endgenerate

  // Register every channel word at the end of CAP.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      for (int c = 0; c < CH_NUM; c++) begin
        res_reg[c] <= '0;
      end
    end else if (capture) begin
      for (int c = 0; c < CH_NUM; c++) begin
        res_reg[c] <= lane_act[c*WORD_W +: WORD_W];
      end
    end
  end

  // Drain port reads straight from the capture registers, so data and
  // channel hold by construction while the consumer stalls.
  assign wr_ch   = ch_reg;
  assign wr_data = res_reg[ch_reg];

endmodule

// File: tb/tb_acc_drain_ctrl.sv
// Directed testbench for acc_drain_ctrl with a cycle-level reference
// model and literal checks on hand-computed results.
module tb_acc_drain_ctrl;

  localparam int AW   = 29;
  localparam int FW   = 8 * 4 * AW;
  localparam int WW   = 48;

  logic          clk;
  logic          srst_n;
  logic          start;
  logic [6:0]    num_steps_m1;
  logic [4:0]    shift;
  logic          relu_en;
  logic [63:0]   bias_vec;
  logic [FW-1:0] add_flat;
  logic [6:0]    counter;
  logic          busy;
  logic          wr_valid;
  logic          wr_ready;
  logic [2:0]    wr_ch;
  logic [WW-1:0] wr_data;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [WW-1:0] got_word [8];

  acc_drain_ctrl dut (
    .clk          (clk),
    .srst_n       (srst_n),
    .start        (start),
    .num_steps_m1 (num_steps_m1),
    .shift        (shift),
    .relu_en      (relu_en),
    .bias_vec     (bias_vec),
    .add_flat     (add_flat),
    .counter      (counter),
    .busy         (busy),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_ch        (wr_ch),
    .wr_data      (wr_data),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference requantisation straight from the arithmetic definition.
  function automatic logic [11:0] ref_q(input longint acc, input longint b,
                                        input bit relu, input int sh);
    longint v;
    v = acc + b;
    if (relu && v < 0) v = 0;
    if (sh > 0) v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
    return v[11:0];
  endfunction

  function automatic logic [FW-1:0] garbage();
    logic [FW-1:0] g;
    for (int i = 0; i < FW / 32; i++) g[i*32 +: 32] = $urandom;
    return g;
  endfunction

  function automatic logic [AW-1:0] rnd_lane();
    int sel;
    sel = $urandom_range(0, 2);
    if (sel == 0) return AW'(int'($urandom_range(0, 8000)) - 4000);
    if (sel == 1) return AW'(int'($urandom_range(0, 200000)) - 100000);
    return AW'($urandom);
  endfunction

  function automatic logic [FW-1:0] rnd_flat();
    logic [FW-1:0] f;
    for (int i = 0; i < 32; i++) f[i*AW +: AW] = rnd_lane();
    return f;
  endfunction

  // ---------------- reference model ----------------
  // Tracks cycles since the accepted start (m_k) and words delivered.
  bit            m_active = 1'b0;
  int            m_k      = 0;
  int            m_n      = 0;
  int            m_shift  = 0;
  bit            m_relu   = 1'b0;
  logic [63:0]   m_bias   = '0;
  int            m_words  = 0;
  logic [WW-1:0] exp_word [8];
  logic signed [AW-1:0] m_a;
  logic signed [7:0]    m_b;

  always @(posedge clk) begin
    if (!srst_n) begin
      m_active = 1'b0;
      m_words  = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_k      = 1;
        m_n      = int'(num_steps_m1);
        m_shift  = int'(shift);
        m_relu   = relu_en;
        m_bias   = bias_vec;
        m_words  = 0;
      end
    end else begin
      if (m_k == m_n + 2) begin
        for (int c = 0; c < 8; c++) begin
          for (int p = 0; p < 4; p++) begin
            m_a = add_flat[(c*4+p)*AW +: AW];
            m_b = m_bias[c*8 +: 8];
            exp_word[c][p*12 +: 12] = ref_q(longint'(m_a), longint'(m_b), m_relu, m_shift);
          end
        end
      end
      if (m_words == 8) m_active = 1'b0;
      else if (m_k >= m_n + 3 && wr_ready) m_words++;
      m_k++;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    bit ev;
    #2;
    ev = m_active && (m_k >= m_n + 3) && (m_words < 8);
    chk("cyc_counter", 64'(counter), (m_active && m_k <= m_n + 1) ? 64'(m_k - 1) : 64'd0);
    chk("cyc_busy", 64'(busy), 64'(m_active));
    chk("cyc_wr_valid", 64'(wr_valid), 64'(ev));
    chk("cyc_done", 64'(done), 64'(m_active && m_words == 8));
    chk("cyc_wr_ch", 64'(wr_ch), ev ? 64'(m_words) : 64'd0);
    if (ev) chk("cyc_wr_data", 64'(wr_data), 64'(exp_word[m_words]));
  end

  // ---------------- stimulus ----------------
  task automatic run_tile(input int n, input int sh, input bit relu, input logic [63:0] bias,
                          input logic [FW-1:0] fin, input int stall_at, input int stall_len,
                          input bit stray);
    int first_valid, nacc, dones;
    bit stalled, finished;
    logic [2:0]    st_ch;
    logic [WW-1:0] st_data;
    @(negedge clk);
    num_steps_m1 = 7'(n);
    shift        = 5'(sh);
    relu_en      = relu;
    bias_vec     = bias;
    add_flat     = garbage();
    wr_ready     = 1'b1;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Configuration must have been latched; scramble the live inputs.
    num_steps_m1 = 7'($urandom);
    shift        = 5'($urandom);
    relu_en      = ~relu;
    bias_vec     = {$urandom, $urandom};
    chk("first_acc_counter", 64'(counter), 64'd0);
    chk("first_acc_busy", 64'(busy), 64'd1);
    for (int i = 1; i <= n + 1; i++) begin
      add_flat = garbage();
      @(negedge clk);
      if (i <= n) chk("acc_counter", 64'(counter), 64'(i));
      else        chk("cap_counter", 64'(counter), 64'd0);
    end
    add_flat = fin;
    @(negedge clk);
    add_flat    = garbage();
    first_valid = -1;
    nacc        = 0;
    dones       = 0;
    stalled     = 1'b0;
    finished    = 1'b0;
    st_ch       = '0;
    st_data     = '0;
    for (int j = 0; j < 80 && !finished; j++) begin
      if (j > 0) @(negedge clk);
      wr_ready = !(j >= stall_at && j < stall_at + stall_len);
      if (stalled && wr_valid) begin
        chk("stall_wr_ch", 64'(wr_ch), 64'(st_ch));
        chk("stall_wr_data", 64'(wr_data), 64'(st_data));
      end
      stalled = wr_valid && !wr_ready;
      st_ch   = wr_ch;
      st_data = wr_data;
      if (wr_valid && first_valid < 0) first_valid = j;
      if (wr_valid && wr_ready) begin
        chk("drain_order", 64'(wr_ch), 64'(nacc));
        got_word[wr_ch] = wr_data;
        $display("word n=%0d ch=%0d data=%012h", n, wr_ch, wr_data);
        nacc++;
      end
      if (done) begin
        dones++;
        finished = 1'b1;
      end
      start = stray && (j == 1 || done);
    end
    chk("drain_finished", 64'(finished), 64'd1);
    chk("start_to_valid", 64'(first_valid), 64'd0);
    chk("word_count", 64'(nacc), 64'd8);
    chk("done_pulses", 64'(dones), 64'd1);
    @(negedge clk);
    start = 1'b0;
    chk("done_cleared", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [FW-1:0] fin;
    logic [63:0]   bias;

    srst_n = 1'b0; start = 1'b0; num_steps_m1 = '0; shift = '0; relu_en = 1'b0;
    bias_vec = '0; add_flat = '0; wr_ready = 1'b1;
    #12;
    chk("rst_counter", 64'(counter), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_wr_ch", 64'(wr_ch), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    srst_n = 1'b1;

    // Basic: 3 steps, every lane 100, no bias/shift/relu
    for (int i = 0; i < 32; i++) fin[i*AW +: AW] = AW'(100);
    run_tile(2, 0, 1'b0, 64'd0, fin, 99, 0, 1'b0);
    for (int c = 0; c < 8; c++)
      for (int p = 0; p < 4; p++)
        chk("basic_lane", 64'(got_word[c][p*12 +: 12]), 64'd100);

    // Rounding and saturation with shift=4
    fin = rnd_flat();
    fin[0*AW +: AW] = AW'(23);
    fin[1*AW +: AW] = AW'(24);
    fin[2*AW +: AW] = AW'(-24);
    fin[3*AW +: AW] = AW'(40000);
    fin[4*AW +: AW] = AW'(-40000);
    run_tile(3, 4, 1'b0, 64'd0, fin, 99, 0, 1'b0);
    chk("rnd_23", 64'(got_word[0][0 +: 12]), 64'h001);
    chk("rnd_24", 64'(got_word[0][12 +: 12]), 64'h002);
    chk("rnd_m24", 64'(got_word[0][24 +: 12]), 64'hFFF);
    chk("sat_pos", 64'(got_word[0][36 +: 12]), 64'h7FF);
    chk("sat_neg", 64'(got_word[1][0 +: 12]), 64'h800);

    // ReLU and bias
    fin = rnd_flat();
    for (int p = 0; p < 4; p++) fin[(3*4+p)*AW +: AW] = AW'(100);
    fin[0*AW +: AW]       = AW'(-127);
    fin[1*AW +: AW]       = AW'(5);
    fin[(1*4)*AW +: AW]   = AW'(-1);
    fin[(2*4)*AW +: AW]   = AW'(50);
    bias = '0;
    bias[0*8 +: 8] = 8'd127;
    bias[2*8 +: 8] = 8'd10;
    bias[3*8 +: 8] = 8'h80;
    run_tile(1, 0, 1'b1, bias, fin, 99, 0, 1'b0);
    for (int p = 0; p < 4; p++) chk("relu_ch3", 64'(got_word[3][p*12 +: 12]), 64'd0);
    chk("relu_bias_cancel", 64'(got_word[0][0 +: 12]), 64'd0);
    chk("bias_pos", 64'(got_word[0][12 +: 12]), 64'd132);
    chk("relu_m1", 64'(got_word[1][0 +: 12]), 64'd0);
    chk("bias_ch2", 64'(got_word[2][0 +: 12]), 64'd60);

    // Backpressure: stall 3 cycles while wr_ch=2
    run_tile(5, 3, 1'b0, {$urandom, $urandom}, rnd_flat(), 2, 3, 1'b0);

    // Reset during ACC at step 5 of 32, then restart
    @(negedge clk);
    num_steps_m1 = 7'd31; shift = '0; relu_en = 1'b0; bias_vec = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_step5", 64'(counter), 64'd5);
    srst_n = 1'b0;
    #1;
    chk("mid_rst_counter", 64'(counter), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    srst_n = 1'b1;
    run_tile(4, 2, 1'b0, {$urandom, $urandom}, rnd_flat(), 99, 0, 1'b0);

    // Single ACC cycle with stray starts during DRAIN and on done
    run_tile(0, 2, 1'b1, {$urandom, $urandom}, rnd_flat(), 99, 0, 1'b1);
    run_tile(1, 1, 1'b0, {$urandom, $urandom}, rnd_flat(), 4, 1, 1'b0);

    // Longest tile with the largest shift
    run_tile(127, 24, 1'b0, {$urandom, $urandom}, garbage(), 99, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/acc_drain_ctrl.md
Name: acc_drain_ctrl

Overview:
- Sequencer and consumer for the 8-channel, 4-pixel conv3 partial-sum accumulator.
- Drives the accumulator's step counter for a programmed number of input channels and captures the final sums one cycle after the last step.
- Applies bias, optional ReLU, a rounding right-shift and saturation to activation width.
- Drains the results one output channel per handshake to the activation SRAM writer.

Parameters:
- ADDER_BW, 29, accumulator lane width (signed).
- BW_PER_ACT, 12, output activation width (signed).
- BW_PER_PARAM, 8, bias width (signed).
- CH_NUM, 8, output channels per accumulator bank (fixed lane count).
- ACT_PER_ADDR, 4, pixels per channel word.
- CNT_W, 7, accumulator step counter width.
- SHIFT_W, 5, requantization shift width.

Ports:
- clk  in  1  clock; single clock domain.
- srst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a tile; honoured only in IDLE.
- num_steps_m1  in  CNT_W  last counter value, i.e. accumulation steps minus 1. Sampled at start.
- shift  in  SHIFT_W  arithmetic right-shift amount, 0..24. Sampled at start.
- relu_en  in  1  clamp negatives to 0. Sampled at start.
- bias_vec  in  CH_NUM*BW_PER_PARAM  signed per-channel bias; ch0 occupies the LSBs. Sampled at start.
- add_flat  in  CH_NUM*ACT_PER_ADDR*ADDER_BW  accumulator outputs. ch0 is at the LSBs; within a channel, pixel0 is at the LSBs.
- counter  out  CNT_W  step index to the accumulator; 0 means load, otherwise accumulate.
- busy  out  1  high in any state other than IDLE.
- wr_valid  out  1  wr_data/wr_ch are valid.
- wr_ready  in  1  downstream accepts the current word.
- wr_ch  out  3  output channel index of the current word.
- wr_data  out  ACT_PER_ADDR*BW_PER_ACT  four saturated activations; pixel0 is at the LSBs.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async assert, sync deassert use): state IDLE, counter=0, busy=0, wr_valid=0, wr_ch=0, wr_data=0, done=0, and all capture registers = 0. Reset mid-tile abandons the tile immediately; no done is produced.
- FSM states: IDLE, ACC, CAP, DRAIN.
- IDLE:
  - counter=0.
  - start=1 latches the configuration and moves to ACC. The step register is 0 on the first ACC cycle.
- ACC:
  - counter = step register, incremented each cycle.
  - When the step equals num_steps_m1, the next state is CAP.
  - num_steps_m1=0 gives exactly one ACC cycle.
  - Upstream must present the conv3 result for step k in the same cycle that counter=k.
- CAP (one cycle):
  - counter=0.
  - add_flat holds the final sums (the accumulator's one-cycle register latency).
  - At the end of CAP, all 32 lanes are post-processed and registered. Then go to DRAIN with wr_ch=0.
- Post-processing per lane, in full precision, with no intermediate wrap:
  1. v = acc + sign_extend(bias[ch]), computed in ADDER_BW+1 bits.
  2. If relu_en and v<0, v=0.
  3. If shift>0, v = (v + 2^(shift-1)) >>> shift (round half up, arithmetic).
  4. Saturate to [-2048, 2047].
- DRAIN:
  - wr_valid=1; wr_data is the registered result for wr_ch.
  - wr_data and wr_ch hold stable while wr_valid && !wr_ready.
  - On acceptance, wr_ch increments.
  - Acceptance at wr_ch=7: wr_valid=0, done=1 for the next cycle, then IDLE.
- Word rate: back-to-back acceptance gives one word per cycle (8 cycles minimum).
- start outside IDLE is ignored. start in the same cycle that done is high is ignored, because the FSM is still leaving DRAIN.
- Tile latency from start to first wr_valid: num_steps_m1+3 cycles.
- counter never exceeds num_steps_m1 and does not wrap. num_steps_m1=127 is legal.

Decomposition:
- Shared package: ADDER_BW, BW_PER_ACT, BW_PER_PARAM, CH_NUM, ACT_PER_ADDR, the state enum (IDLE/ACC/CAP/DRAIN), and the saturation bounds ACT_MAX=2047 and ACT_MIN=-2048.
- One natural sub-module, requant_lane: a combinational bias + ReLU + rounding-shift + saturate for one lane. It is instantiated 32 times in a generate loop.

Test Plan:
- Reset mid-ACC: assert srst_n=0 at step 5 of 32 -> counter=0, busy=0, wr_valid=0 immediately; the next start restarts from counter=0.
- num_steps_m1=2, shift=0, bias=0, relu off, add_flat lane=100 at CAP -> counter sequence 0,1,2,0; wr_valid on cycle 5; all words = 100.
- Rounding and saturation, with shift=4:
  - acc=23, bias=0 -> 1.
  - acc=24 -> 2.
  - acc=-24 -> -1.
  - acc=40000 -> 2047.
  - acc=-40000, relu off -> -2048.
- ReLU and bias: relu_en=1, bias ch3=-128, acc=100 -> 0 for ch3; bias ch0=+127, acc=-127 -> 0; acc=-1 with relu -> 0.
- Backpressure: wr_ready low for 3 cycles at wr_ch=2 -> wr_ch/wr_data stable; 8 words delivered in order 0..7; exactly one done pulse.
- num_steps_m1=0 with a start pulse during DRAIN -> single ACC cycle; the stray start is ignored; a new start after done is accepted.
